ik_iter_ctrl: RTL and testbench
===============================

Name: ik_iter_ctrl

Overview:
Iteration sequencer for the IK datapath. Each iteration, it launches the datapath with the current joint variables q and waits for the joint deltas. It then applies the deltas (q += delta, saturating) and stops on convergence, on the iteration limit, or on abort. It sits between the host register file and the IK solver core, and its q outputs feed the solver's joint-variable inputs.

Parameters:
N_JOINT, 6, number of joints
WORD, 36, signed fixed-point width, 16 fractional bits (65536 = 1.0)
ITER_W, 16, width of max_iter / iter_count
WDOG_CYCLES, 4096, datapath timeout in cycles (used only with IK_WATCHDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a solve
abort  in  1  one-cycle pulse; cancel a solve
max_iter  in  ITER_W  iteration limit, sampled in LOAD
tol  in  WORD  convergence tolerance, unsigned magnitude, sampled in LOAD
joint_mask  in  N_JOINT  1 = joint is updated; 0 = frozen
q_init  in  N_JOINT*WORD  initial joint variables, sampled in LOAD
dp_rst  out  1  datapath reset; high except in LAUNCH/WAIT
dp_start  out  1  one-cycle launch pulse
dp_done  in  1  datapath result valid (pulse)
dp_delta  in  N_JOINT*WORD  signed joint deltas, valid with dp_done
q  out  N_JOINT*WORD  current joint variables
busy  out  1  high in LOAD..CHECK
done  out  1  level; solve finished
converged  out  1  valid when done
err  out  1  watchdog timeout (0 when feature compiled out)
iter_count  out  ITER_W  completed iterations

Behaviour:
- Reset values: all outputs 0, except dp_rst=1. q=0; state IDLE.
- States and transitions:
  - IDLE: start -> LOAD. Entering LOAD clears done, converged, err and iter_count.
  - LOAD: capture q_init, tol and max_iter. If max_iter==0 -> DONE with converged=0 and no launch; else -> LAUNCH.
  - LAUNCH: dp_rst=0, dp_start=1 for exactly one cycle -> WAIT.
  - WAIT: dp_rst=0. dp_done -> UPDATE, capturing dp_delta into delta_r.
  - UPDATE, per joint i:
    - joint_mask[i]=1: q[i] <= sat(q[i] + delta_r[i]), computed at WORD+1 bits and clamped to [-2^35, 2^35-1].
    - joint_mask[i]=0: q[i] unchanged.
    - iter_count++.
    - conv_r <= AND over masked joints of |delta_r[i]| <= tol; |-2^35| is taken as 2^35-1. An all-zero mask gives conv_r=1.
  - CHECK: conv_r -> DONE with converged=1; else iter_count==max_iter -> DONE with converged=0; else -> LAUNCH.
  - DONE: done=1, busy=0 -> IDLE the next cycle. done stays high until the next start.
- Latency: start pulse at cycle 0 -> dp_start at cycle 2. dp_done at cycle k -> q updated visible at k+2. Next dp_start at k+3 when not finished.
- dp_done is sampled only in WAIT; it is ignored in every other state, including the LAUNCH cycle.
- start while busy is ignored.
- abort in any non-IDLE state -> IDLE next cycle: busy=0, done=0, q held, dp_rst=1. A late dp_done is ignored.
- abort and start in the same IDLE cycle: abort wins and start is ignored.
- Asynchronous reset mid-solve returns every register to its reset value immediately.

Optional Feature:
IK_WATCHDOG_EN
- Defined: a counter runs in WAIT. If it reaches WDOG_CYCLES without dp_done -> DONE with err=1, converged=0, q unchanged. The counter clears on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Decomposition:
- Package ik_ctrl_pkg holds:
  - state enum (IDLE, LOAD, LAUNCH, WAIT, UPDATE, CHECK, DONE)
  - WORD and Q_FRAC=16 constants
  - sat_add and abs_mag functions
- Sub-module ik_ctrl_joint_upd: one joint's saturating add plus tolerance compare, instantiated N_JOINT times with generate.

Test Plan:
1. q_init all 0, tol=655, max_iter=4, mask=6'h3F; delta 65536 on iteration 1, then 300 on iteration 2 -> done=1, converged=1, iter_count=2, every q=65836.
2. Constant delta 65536, tol=655, max_iter=3 -> done=1, converged=0, iter_count=3, q=196608; exactly 3 dp_start pulses.
3. q_init[0]=2^35-100, delta[0]=+1000 -> q[0]=2^35-1. q_init[1]=-2^35+5, delta[1]=-50 -> q[1]=-2^35.
4. mask=6'b000001, all deltas 4096 -> only q[0] changes. Mask=0 -> converged=1 after iteration 1.
5. abort on the 3rd WAIT cycle, then dp_done pulse -> busy=0, done=0, q unchanged. start during busy -> no effect. max_iter=0 -> done at cycle 2, converged=0, no dp_start.
6. Reset asserted mid-WAIT -> all outputs 0 and dp_rst=1 immediately. With IK_WATCHDOG_EN and WDOG_CYCLES=16 and dp_done never asserted -> err=1, done=1 after 16 WAIT cycles.

Source files
------------

// File: rtl/ik_ctrl_pkg.sv
// Shared types and fixed-point helpers for the IK iteration sequencer.
// Joint words are signed WORD-bit fixed point with Q_FRAC fractional bits.
package ik_ctrl_pkg;

  localparam int WORD   = 36;
  localparam int Q_FRAC = 16;

  localparam logic signed [WORD-1:0] Q_MAX = {1'b0, {(WORD-1){1'b1}}};
  localparam logic signed [WORD-1:0] Q_MIN = {1'b1, {(WORD-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT,
    UPDATE,
    CHECK,
    DONE
  } state_t;

  // One guard bit catches overflow; clamp to the representable range.
  function automatic logic signed [WORD-1:0] sat_add(input logic signed [WORD-1:0] a,
                                                    input logic signed [WORD-1:0] b);
    logic signed [WORD:0] s;
    s = {a[WORD-1], a} + {b[WORD-1], b};
    if (s[WORD] != s[WORD-1]) begin
      return s[WORD] ? Q_MIN : Q_MAX;
    end
    return s[WORD-1:0];
  endfunction

  // The most negative value has no positive twin, so it maps to Q_MAX.
  function automatic logic [WORD-1:0] abs_mag(input logic signed [WORD-1:0] x);
    if (x == Q_MIN) begin
      return Q_MAX;
    end
    if (x[WORD-1]) begin
      return WORD'(-x);
    end
    return x;
  endfunction

endpackage

// File: rtl/ik_ctrl_joint_upd.sv
// One joint's update step: saturating q + delta and the per-joint tolerance test.
// A frozen joint holds its value and never blocks convergence.
module ik_ctrl_joint_upd
  import ik_ctrl_pkg::*;
(
  input  logic [WORD-1:0] i_q,
  input  logic [WORD-1:0] i_delta,
  input  logic [WORD-1:0] i_tol,
  input  logic            i_mask,
  output logic [WORD-1:0] o_q_next,
  output logic            o_within
);

  logic [WORD-1:0] w_sum;

  assign w_sum    = sat_add(i_q, i_delta);
  assign o_q_next = i_mask ? w_sum : i_q;
  assign o_within = !i_mask || (abs_mag(i_delta) <= i_tol);

endmodule

// File: rtl/ik_iter_ctrl.sv
// Iteration sequencer for the IK datapath: launch, wait, apply deltas, test for stop.
// Optional datapath watchdog enabled by defining IK_WATCHDOG_EN.
module ik_iter_ctrl
  import ik_ctrl_pkg::*;
#(
  parameter int N_JOINT = 6,
  parameter int ITER_W  = 16
`ifdef IK_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [ITER_W-1:0]         i_max_iter,
  input  logic [WORD-1:0]           i_tol,
  input  logic [N_JOINT-1:0]        i_joint_mask,
  input  logic [N_JOINT*WORD-1:0]   i_q_init,
  output logic                      o_dp_rst,
  output logic                      o_dp_start,
  input  logic                      i_dp_done,
  input  logic [N_JOINT*WORD-1:0]   i_dp_delta,
  output logic [N_JOINT*WORD-1:0]   o_q,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_converged,
  output logic                      o_err,
  output logic [ITER_W-1:0]         o_iter_count
);

  state_t                    r_state, w_next;
  logic [N_JOINT*WORD-1:0]   r_q, r_delta, w_q_next;
  logic [N_JOINT-1:0]        w_within;
  logic [WORD-1:0]           r_tol;
  logic [ITER_W-1:0]         r_max_iter, r_iter;
  logic                      r_conv, r_done, r_converged;
  logic                      w_wdog_exp;

`ifdef IK_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  // Counter is held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog <= '0;
    end else if (r_state != WAIT) begin
      r_wdog <= '0;
    end else if (!i_dp_done) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_wdog_exp = (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign o_err      = r_err;
`else
  assign w_wdog_exp = 1'b0;
  assign o_err      = 1'b0;
`endif

  for (genvar g = 0; g < N_JOINT; g++) begin : g_joint
    ik_ctrl_joint_upd u_upd (
      .i_q      (r_q[g*WORD +: WORD]),
      .i_delta  (r_delta[g*WORD +: WORD]),
      .i_tol    (r_tol),
      .i_mask   (i_joint_mask[g]),
      .o_q_next (w_q_next[g*WORD +: WORD]),
      .o_within (w_within[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort from any active state overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start && !i_abort) w_next = LOAD;
      LOAD:    w_next = (i_max_iter == '0) ? DONE : LAUNCH;
      LAUNCH:  w_next = WAIT;
      WAIT: begin
        if (i_dp_done)       w_next = UPDATE;
        else if (w_wdog_exp) w_next = DONE;
      end
      UPDATE:  w_next = CHECK;
      CHECK: begin
        if (r_conv)                    w_next = DONE;
        else if (r_iter == r_max_iter) w_next = DONE;
        else                           w_next = LAUNCH;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_abort && r_state != IDLE) w_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q         <= '0;
      r_delta     <= '0;
      r_tol       <= '0;
      r_max_iter  <= '0;
      r_iter      <= '0;
      r_conv      <= 1'b0;
      r_done      <= 1'b0;
      r_converged <= 1'b0;
`ifdef IK_WATCHDOG_EN
      r_err       <= 1'b0;
`endif
    end else if (i_abort && r_state != IDLE) begin
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_done      <= 1'b0;
            r_converged <= 1'b0;
            r_iter      <= '0;
`ifdef IK_WATCHDOG_EN
            r_err       <= 1'b0;
`endif
          end
        end
        LOAD: begin
          r_q        <= i_q_init;
          r_tol      <= i_tol;
          r_max_iter <= i_max_iter;
          if (i_max_iter == '0) r_done <= 1'b1;
        end
        WAIT: begin
          if (i_dp_done) begin
            r_delta <= i_dp_delta;
          end
`ifdef IK_WATCHDOG_EN
          else if (w_wdog_exp) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end
`endif
        end
        UPDATE: begin
          r_q    <= w_q_next;
          r_iter <= r_iter + ITER_W'(1);
          r_conv <= &w_within;
        end
        CHECK: begin
          if (r_conv) begin
            r_done      <= 1'b1;
            r_converged <= 1'b1;
          end else if (r_iter == r_max_iter) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state == LOAD) || (r_state == LAUNCH) || (r_state == WAIT) ||
                        (r_state == UPDATE) || (r_state == CHECK);
  assign o_dp_rst     = !((r_state == LAUNCH) || (r_state == WAIT));
  assign o_dp_start   = (r_state == LAUNCH);
  assign o_q          = r_q;
  assign o_done       = r_done;
  assign o_converged  = r_converged;
  assign o_iter_count = r_iter;

endmodule

// File: tb/tb_ik_iter_ctrl.sv
// Self-checking bench for ik_iter_ctrl: table-driven solves with a scoreboard,
// plus hand-written latency, abort, reset and (with IK_WATCHDOG_EN) watchdog sequences.
module tb_ik_iter_ctrl;

  localparam int N  = 6;
  localparam int W  = 36;
  localparam int IW = 16;

  typedef struct {
    logic [IW-1:0]  maxIter;
    logic [W-1:0]   tol;
    logic [N-1:0]   mask;
    logic [N*W-1:0] qInit;
    logic [N*W-1:0] delta1;
    logic [N*W-1:0] delta2;
    logic           pokeStart;
    logic           expConv;
    int             expIter;
    int             expStarts;
    logic [N*W-1:0] expQ;
  } vec_t;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_abort = 1'b0;
  logic [IW-1:0]  i_max_iter = '0;
  logic [W-1:0]   i_tol = '0;
  logic [N-1:0]   i_joint_mask = '0;
  logic [N*W-1:0] i_q_init = '0;
  logic           i_dp_done = 1'b0;
  logic [N*W-1:0] i_dp_delta = '0;
  logic           o_dp_rst, o_dp_start, o_busy, o_done, o_converged, o_err;
  logic [N*W-1:0] o_q;
  logic [IW-1:0]  o_iter_count;

  int   nCompared = 0;
  int   nMismatch = 0;
  vec_t vecs[8];
  vec_t sb[$];

  ik_iter_ctrl #(
    .N_JOINT(N),
    .ITER_W (IW)
`ifdef IK_WATCHDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_max_iter   (i_max_iter),
    .i_tol        (i_tol),
    .i_joint_mask (i_joint_mask),
    .i_q_init     (i_q_init),
    .o_dp_rst     (o_dp_rst),
    .o_dp_start   (o_dp_start),
    .i_dp_done    (i_dp_done),
    .i_dp_delta   (i_dp_delta),
    .o_q          (o_q),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_converged  (o_converged),
    .o_err        (o_err),
    .o_iter_count (o_iter_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
    return {N{v}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkQ(input string name, input int j, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = o_q[j*W +: W];
    checkOutput($sformatf("%s q[%0d]", name, j), 64'(act), 64'(exp));
  endtask

  // Drives one solve, acting as the datapath (2-cycle latency after dp_start).
  task automatic applyStimulus(input int idx, input vec_t v);
    int   starts, countdown, iterIdx, cyc;
    vec_t e;
    i_max_iter   = v.maxIter;
    i_tol        = v.tol;
    i_joint_mask = v.mask;
    i_q_init     = v.qInit;
    sb.push_back(v);
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    starts = 0; countdown = 0; iterIdx = 0; cyc = 0;
    while (!o_done && cyc < 400) begin
      i_start   = 1'b0;
      i_dp_done = 1'b0;
      if (o_dp_start) begin
        starts++;
        countdown = 2;
        if (v.pokeStart && starts == 2) begin
          i_start  = 1'b1;
          i_q_init = rep(36'd5000);
        end
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          i_dp_done  = 1'b1;
          i_dp_delta = (iterIdx == 0) ? v.delta1 : v.delta2;
          iterIdx++;
        end
      end
      tick();
      cyc++;
    end
    i_start   = 1'b0;
    i_dp_done = 1'b0;
    checkOutput($sformatf("vec%0d done reached", idx), 64'(o_done), 64'd1);
    e = sb.pop_front();
    checkOutput($sformatf("vec%0d converged", idx), 64'(o_converged), 64'(e.expConv));
    checkOutput($sformatf("vec%0d iter_count", idx), 64'(o_iter_count), 64'(e.expIter));
    checkOutput($sformatf("vec%0d dp_start count", idx), 64'(starts), 64'(e.expStarts));
    checkOutput($sformatf("vec%0d err", idx), 64'(o_err), 64'd0);
    checkOutput($sformatf("vec%0d busy", idx), 64'(o_busy), 64'd0);
    for (int j = 0; j < N; j++) begin
      checkQ($sformatf("vec%0d", idx), j, e.expQ[j*W +: W]);
    end
  endtask

  initial begin
    vec_t v;

    // Converges on the second iteration
    v = '{maxIter: 16'd4, tol: 36'd655, mask: 6'h3F, qInit: rep(36'd0), delta1: rep(36'd65536),
          delta2: rep(36'd300), pokeStart: 1'b0, expConv: 1'b1, expIter: 2, expStarts: 2,
          expQ: rep(36'd65836)};
    vecs[0] = v;
    // Runs out of iterations
    v = '{maxIter: 16'd3, tol: 36'd655, mask: 6'h3F, qInit: rep(36'd0), delta1: rep(36'd65536),
          delta2: rep(36'd65536), pokeStart: 1'b0, expConv: 1'b0, expIter: 3, expStarts: 3,
          expQ: rep(36'd196608)};
    vecs[1] = v;
    // Positive and negative saturation
    v = '{maxIter: 16'd1, tol: 36'd655, mask: 6'h3F, qInit: rep(36'd0), delta1: rep(36'd0),
          delta2: rep(36'd0), pokeStart: 1'b0, expConv: 1'b0, expIter: 1, expStarts: 1,
          expQ: rep(36'd0)};
    v.qInit[0*W +: W]  = 36'h7FFFFFF9C;
    v.qInit[1*W +: W]  = 36'h800000005;
    v.delta1[0*W +: W] = 36'd1000;
    v.delta1[1*W +: W] = 36'hFFFFFFFCE;
    v.delta2 = v.delta1;
    v.expQ[0*W +: W]   = 36'h7FFFFFFFF;
    v.expQ[1*W +: W]   = 36'h800000000;
    vecs[2] = v;
    // Only joint 0 enabled
    v = '{maxIter: 16'd1, tol: 36'd655, mask: 6'h01, qInit: rep(36'd0), delta1: rep(36'd4096),
          delta2: rep(36'd4096), pokeStart: 1'b0, expConv: 1'b0, expIter: 1, expStarts: 1,
          expQ: rep(36'd0)};
    v.expQ[0*W +: W] = 36'd4096;
    vecs[3] = v;
    // Empty mask converges immediately and freezes q
    v = '{maxIter: 16'd4, tol: 36'd655, mask: 6'h00, qInit: rep(36'd7), delta1: rep(36'd4096),
          delta2: rep(36'd4096), pokeStart: 1'b0, expConv: 1'b1, expIter: 1, expStarts: 1,
          expQ: rep(36'd7)};
    vecs[4] = v;
    // |-2^35| treated as 2^35-1, equal to tol
    v = '{maxIter: 16'd3, tol: 36'h7FFFFFFFF, mask: 6'h01, qInit: rep(36'd0), delta1: rep(36'd0),
          delta2: rep(36'd0), pokeStart: 1'b0, expConv: 1'b1, expIter: 1, expStarts: 1,
          expQ: rep(36'd0)};
    v.delta1[0*W +: W] = 36'h800000000;
    v.delta2 = v.delta1;
    v.expQ[0*W +: W]   = 36'h800000000;
    vecs[5] = v;
    // start while busy must not reload q_init
    v = '{maxIter: 16'd2, tol: 36'd10, mask: 6'h3F, qInit: rep(36'd0), delta1: rep(36'd100),
          delta2: rep(36'd100), pokeStart: 1'b1, expConv: 1'b0, expIter: 2, expStarts: 2,
          expQ: rep(36'd200)};
    vecs[6] = v;
    // max_iter = 0 finishes without launching
    v = '{maxIter: 16'd0, tol: 36'd10, mask: 6'h3F, qInit: rep(36'd123), delta1: rep(36'd100),
          delta2: rep(36'd100), pokeStart: 1'b0, expConv: 1'b0, expIter: 0, expStarts: 0,
          expQ: rep(36'd123)};
    vecs[7] = v;

    // Reset state
    #12;
    checkOutput("reset dp_rst", 64'(o_dp_rst), 64'd1);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset done", 64'(o_done), 64'd0);
    checkOutput("reset q", 64'(o_q[63:0]), 64'd0);
    checkOutput("reset iter", 64'(o_iter_count), 64'd0);
    #2 i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Latency and abort sequence
    i_max_iter = 16'd5; i_tol = 36'd10; i_joint_mask = 6'h3F; i_q_init = rep(36'd0);
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    checkOutput("lat c1 dp_start", 64'(o_dp_start), 64'd0);
    checkOutput("lat c1 busy", 64'(o_busy), 64'd1);
    tick();
    checkOutput("lat c2 dp_start", 64'(o_dp_start), 64'd1);
    checkOutput("lat c2 dp_rst", 64'(o_dp_rst), 64'd0);
    tick();
    checkOutput("lat c3 dp_start", 64'(o_dp_start), 64'd0);
    tick(); i_dp_done = 1'b1; i_dp_delta = rep(36'd100);
    tick(); i_dp_done = 1'b0;
    checkQ("lat k+1", 0, 36'd0);
    tick();
    checkQ("lat k+2", 0, 36'd100);
    checkOutput("lat k+2 iter", 64'(o_iter_count), 64'd1);
    tick();
    checkOutput("lat k+3 dp_start", 64'(o_dp_start), 64'd1);
    tick(); tick(); tick(); i_abort = 1'b1;
    tick(); i_abort = 1'b0;
    checkOutput("abort busy", 64'(o_busy), 64'd0);
    checkOutput("abort done", 64'(o_done), 64'd0);
    checkOutput("abort dp_rst", 64'(o_dp_rst), 64'd1);
    checkQ("abort", 0, 36'd100);
    i_dp_done = 1'b1; i_dp_delta = rep(36'd999);
    tick(); i_dp_done = 1'b0;
    tick();
    checkQ("late dp_done", 0, 36'd100);
    checkOutput("late dp_done busy", 64'(o_busy), 64'd0);

    // abort and start together in IDLE
    i_start = 1'b1; i_abort = 1'b1;
    tick(); i_start = 1'b0; i_abort = 1'b0;
    checkOutput("abort+start busy", 64'(o_busy), 64'd0);
    tick();
    checkOutput("abort+start dp_start", 64'(o_dp_start), 64'd0);

    // max_iter = 0 timing
    i_max_iter = 16'd0;
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    checkOutput("max0 c1 busy", 64'(o_busy), 64'd1);
    tick();
    checkOutput("max0 c2 done", 64'(o_done), 64'd1);
    checkOutput("max0 c2 dp_start", 64'(o_dp_start), 64'd0);

    // Asynchronous reset mid-WAIT
    i_max_iter = 16'd5; i_q_init = rep(36'd1000);
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick();
    checkQ("pre-reset", 0, 36'd1000);
    #2 i_rst_n = 1'b0;
    #1;
    checkQ("async reset", 0, 36'd0);
    checkOutput("async reset busy", 64'(o_busy), 64'd0);
    checkOutput("async reset dp_rst", 64'(o_dp_rst), 64'd1);
    checkOutput("async reset iter", 64'(o_iter_count), 64'd0);
    #2 i_rst_n = 1'b1;
    tick();

`ifdef IK_WATCHDOG_EN
    // Datapath never answers
    i_max_iter = 16'd5;
    tick(); i_start = 1'b1;
    tick(); i_start = 1'b0;
    repeat (17) tick();
    checkOutput("wdog c18 done", 64'(o_done), 64'd0);
    tick();
    checkOutput("wdog c19 done", 64'(o_done), 64'd1);
    checkOutput("wdog c19 err", 64'(o_err), 64'd1);
    checkOutput("wdog c19 converged", 64'(o_converged), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
